// File: rtl/sq_16bit.sv
// Sequential 16-bit unsigned squarer: O = A * A by shift-and-add, one multiplier bit per clock.
// Used to square a computed root so it can be checked against the original radicand.
module sq_16bit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] A,
  output logic [31:0] O,
  output logic        BUSY,
  output logic        DONE
);

  // state | meaning
  // IDLE  | waiting for START; O holds last result
  // CALC  | 16 shift-and-add iterations in progress
  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] m_q, m_d;
  logic [15:0] q_q, q_d;
  logic [31:0] p_q, p_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] o_q, o_d;
  logic        done_q, done_d;
  logic [31:0] p_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = CALC;
      CALC:    if (cnt_q == 4'd15) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result never exceeds 0xFFFE0001, so the 32-bit add needs no carry-out.
  assign p_next = p_q + (q_q[0] ? m_q : 32'd0);

  always_comb begin
    m_d    = m_q;
    q_d    = q_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    o_d    = o_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          m_d   = {16'd0, A};
          q_d   = A;
          p_d   = '0;
          cnt_d = '0;
        end
      end
      CALC: begin
        p_d   = p_next;
        m_d   = m_q << 1;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          o_d    = p_next;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    BUSY = (state_q == CALC);
    DONE = done_q;
    O    = o_q;
  end

endmodule

// File: tb/tb_sq_16bit.sv
// Directed bench for sq_16bit: stimulus pushes expected squares into a queue,
// a negedge monitor pops and compares on every DONE pulse.
module tb_sq_16bit;

  logic        CLK = 1'b0;
  logic        RST, START;
  logic [15:0] A;
  logic [31:0] O;
  logic        BUSY, DONE;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_o;

  sq_16bit dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A),
    .O(O), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard compare on DONE, plus DONE/BUSY exclusivity every cycle.
  always @(negedge CLK) begin
    if (DONE === 1'b1 && BUSY === 1'b1) begin
      errors++;
      $display("FAIL done_busy_overlap: DONE=1 BUSY=1 expected not both");
    end
    if (DONE === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: O=0x%08h with no pending request", O);
      end else begin
        chk("result", O, exp_q.pop_front());
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (DONE !== 1'b1 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (DONE !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no DONE after %0d cycles expected DONE", n);
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [31:0] exp);
    int n, busy_n;
    @(negedge CLK);
    START = 1'b1;
    A = a;
    exp_q.push_back(exp);
    @(negedge CLK);
    START = 1'b0;
    A = ~a;
    chk("o_hold_during_calc", O, last_o);
    n = 0;
    busy_n = 0;
    while (DONE !== 1'b1 && n < 40) begin
      if (BUSY === 1'b1) busy_n++;
      @(negedge CLK);
      n++;
    end
    if (DONE !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: A=0x%04h no DONE expected DONE", a);
    end else begin
      chk("latency", 32'(n), 32'd16);
      chk("busy_cycles", 32'(busy_n), 32'd16);
      last_o = exp;
      @(negedge CLK);
      chk("done_one_cycle", {31'd0, DONE}, 32'd0);
    end
  endtask

  typedef struct { logic [15:0] a; logic [31:0] exp; } vec_t;
  vec_t vecs[6] = '{
    '{16'h0003, 32'h00000009},
    '{16'h0000, 32'h00000000},
    '{16'hFFFF, 32'hFFFE0001},
    '{16'h0100, 32'h00010000},
    '{16'h00FF, 32'h0000FE01},
    '{16'hB504, 32'h7FFEA810}
  };

  initial begin
    int n, n2, dc;
    RST = 1'b1;
    START = 1'b0;
    A = '0;
    last_o = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("reset_o", O, 32'd0);
    chk("reset_busy", {31'd0, BUSY}, 32'd0);
    chk("reset_done", {31'd0, DONE}, 32'd0);
    repeat (20) @(negedge CLK);
    chk("idle_o", O, 32'd0);
    chk("idle_busy", {31'd0, BUSY}, 32'd0);
    chk("idle_no_done", 32'(done_cnt), 32'd0);

    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].exp);

    // START pulsed at cycle 5 of CALC must be ignored.
    dc = done_cnt;
    @(negedge CLK);
    START = 1'b1; A = 16'h0005; exp_q.push_back(32'h00000019);
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    START = 1'b1; A = 16'h0007;
    @(negedge CLK);
    START = 1'b0; A = '0;
    wait_done(n);
    repeat (25) @(negedge CLK);
    chk("busy_start_single_done", 32'(done_cnt - dc), 32'd1);
    chk("busy_start_o", O, 32'h00000019);

    // Back-to-back: START held, new operand accepted in the DONE cycle.
    @(negedge CLK);
    START = 1'b1; A = 16'h0010; exp_q.push_back(32'h00000100);
    @(negedge CLK);
    wait_done(n);
    A = 16'h0011; exp_q.push_back(32'h00000121);
    @(negedge CLK);
    START = 1'b0;
    chk("b2b_busy_after_done", {31'd0, BUSY}, 32'd1);
    wait_done(n2);
    chk("b2b_gap", 32'(n2 + 1), 32'd17);
    @(negedge CLK);

    // RST and START together: reset wins.
    RST = 1'b1; START = 1'b1; A = 16'h0009;
    @(negedge CLK);
    RST = 1'b0; START = 1'b0;
    chk("rst_start_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_start_o", O, 32'd0);
    repeat (20) @(negedge CLK);
    chk("rst_start_no_calc", {31'd0, BUSY}, 32'd0);

    // Reset at cycle 8 of CALC aborts without a DONE.
    dc = done_cnt;
    START = 1'b1; A = 16'h1234;
    @(negedge CLK);
    START = 1'b0;
    repeat (7) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_o", O, 32'd0);
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_done", {31'd0, DONE}, 32'd0);
    repeat (20) @(negedge CLK);
    chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
    last_o = '0;
    do_op(16'h0002, 32'h00000004);

    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sq_16bit.md
# sq_16bit

Sequential 16-bit unsigned squarer computing O = A × A as a 32-bit result by iterative shift-and-add, one multiplier bit per clock. It is the inverse of the square-root datapath. It squares a computed root so the result can be checked against the original radicand, as in root² ≤ X < (root+1)². A start/busy/done handshake lets the sqrt controller or testbench sequence it.

## Interface
Parameters:
- None. Operand width is fixed at 16 bits and result width at 32 bits.

Ports:
- CLK — input, 1 bit. Single clock; all state updates on the rising edge.
- RST — input, 1 bit. Synchronous, active-high reset.
- START — input, 1 bit. Request a new square; sampled only in IDLE.
- A — input, 16 bits. Unsigned operand; sampled on the edge that accepts START.
- O — output, 32 bits. Unsigned result A²; registered; holds its value until the next completion.
- BUSY — output, 1 bit. High while an operation is in progress (state CALC).
- DONE — output, 1 bit. One-cycle pulse; O is valid from the cycle in which DONE is high.

## Operation
- Internal registers:
  - state: IDLE or CALC.
  - M: 32-bit multiplicand.
  - Q: 16-bit multiplier.
  - P: 32-bit accumulator.
  - CNT: 4-bit iteration counter.
- Reset (RST=1 at an edge): state=IDLE, O=0, BUSY=0, DONE=0, P=0, M=0, Q=0, CNT=0. RST has priority over every other input.
- IDLE with START=1 at an edge:
  - M ← {16'b0, A}, Q ← A, P ← 0, CNT ← 0.
  - state ← CALC, BUSY ← 1.
- IDLE with START=0: hold all state. DONE ← 0.
- CALC, one iteration per edge:
  - P_next = P + (Q[0] ? M : 0), as a 32-bit unsigned add.
  - M ← M << 1, Q ← Q >> 1, CNT ← CNT + 1.
- CALC edge with CNT=15 (the 16th iteration):
  - O ← P_next.
  - DONE ← 1, BUSY ← 0, state ← IDLE.
- Width rule: the maximum result is 0xFFFF² = 0xFFFE0001, so the accumulator never overflows and no carry-out is kept. M's top bit shifted out after the 16th shift is discarded; it is always 0 when used.
- START while in CALC is ignored; A changes during CALC have no effect.
- A is zero-extended; there is no signed mode.
- There is no early termination. Every operation takes exactly 16 iterations, even when A=0.

## Timing
- START is sampled at edge k in IDLE. BUSY is high for cycles k+1 through k+16, i.e. 16 cycles.
- At edge k+16: O is updated and DONE rises. DONE is high for exactly one cycle (k+16 to k+17) and BUSY is low in that cycle.
- Latency from the START-sampling edge to O valid is 16 clocks.
- Back-to-back operation: the DONE cycle is in IDLE, so START=1 in that cycle is accepted at edge k+17. Sustained throughput is one result per 17 clocks.
- O is not cleared at START. The previous result stays visible throughout the next CALC.
- Reset mid-CALC aborts the operation at that edge: no DONE pulse, O=0, BUSY=0.
- RST and START asserted at the same edge: reset wins, and START is not accepted.
- DONE and BUSY are never high in the same cycle.

## Test plan
- Reset values: assert RST for 2 cycles, then release → O=0x00000000, BUSY=0, DONE=0; with START=0 nothing changes for 20 cycles.
- Basic values:
  - START with A=0x0003 → BUSY for 16 cycles, DONE pulse with O=0x00000009.
  - A=0x0000 → DONE after 16 cycles, O=0x00000000.
- Extremes:
  - A=0xFFFF → O=0xFFFE0001.
  - A=0x0100 → O=0x00010000.
  - A=0x00FF → O=0x0000FE01.
  - A=0xB504 → O=0x7FFEA810.
- START while busy: START with A=0x0005, then pulse START with A=0x0007 at cycle 5 of CALC → ignored; single DONE with O=0x00000019; next DONE only after a new START.
- Back-to-back: hold START=1 with A=0x0010 and assert A=0x0011 in the DONE cycle → first DONE has O=0x00000100; the second START is accepted in the DONE cycle; the second DONE comes 17 cycles after the first with O=0x00000121.
- Reset mid-operation: START with A=0x1234, assert RST at cycle 8 of CALC → no DONE, O=0, BUSY=0. A following START with A=0x0002 gives O=0x00000004 after 16 cycles.
